// File: rtl/mcp23s17_spi_slave_if.sv
// SPI pin bundle between an MCP23S17-style responder and its bus master.
// Latency/backpressure: none; plain wires, SPI has no flow control.
interface mcp23s17_spi_slave_if;
   logic cs;
   logic sck;
   logic mosi;
   logic miso;
   logic miso_oe;

   modport slave  (input cs, sck, mosi, output miso, miso_oe);
   modport master (output cs, sck, mosi, input miso, miso_oe);
endinterface

// File: rtl/mcp23s17_spi_slave.sv
// MCP23S17 register-subset emulation behind an oversampled SPI mode-0 responder.
// Latency: 3 clk from pin edge to action; no backpressure, sck half-period must be >= 4 clk.
module mcp23s17_spi_slave #(
   parameter logic [2:0] HW_ADDR = 3'b000
) (
   input  logic                        clk,
   input  logic                        rst,
   mcp23s17_spi_slave_if.slave         spi,
   input  logic [7:0]                  gpa_in_i,
   input  logic [7:0]                  gpb_in_i,
   output logic [7:0]                  gpa_out_o,
   output logic [7:0]                  gpa_oe_o,
   output logic [7:0]                  gpb_out_o,
   output logic [7:0]                  gpb_oe_o,
   output logic                        inta_o,
   output logic                        intb_o
);
   localparam logic [1:0] ST_OPCODE = 2'd0;
   localparam logic [1:0] ST_ADDR   = 2'd1;
   localparam logic [1:0] ST_DATA   = 2'd2;
   localparam logic [1:0] ST_IGNORE = 2'd3;

   logic [1:0] cs_sync_q, mosi_sync_q;
   logic [2:0] sck_sync_q;
   logic [7:0] gpa_m_q, gpa_s_q, gpa_prev_q, gpb_m_q, gpb_s_q, gpb_prev_q;
   logic [1:0] state_q, state_d;
   logic [2:0] bit_cnt_q;
   logic [6:0] rx_q;
   logic [7:0] shreg_q, ptr_q, ptr_d;
   logic       rw_q, miso_q, miso_oe_q;
   logic [7:0] iodira_q, iodirb_q, gpintena_q, gpintenb_q, iocon_q, gppua_q, gppub_q;
   logic [7:0] intfa_q, intfb_q, intfa_d, intfb_d, intcapa_q, intcapb_q, olata_q, olatb_q;
   logic [7:0] gpa_out_q, gpa_oe_q, gpb_out_q, gpb_oe_q;

   logic       cs_s, sck_rise, sck_fall, byte_done, load_vld, wr_vld;
   logic       clr_a, clr_b, cap_a, cap_b, int_a, int_b, pin_a, pin_b;
   logic [7:0] rx_byte, ptr_nxt, load_addr, rd_dat, gpio_a_val, gpio_b_val, set_a, set_b;

   assign cs_s      = cs_sync_q[1];
   assign sck_rise  =  sck_sync_q[1] & ~sck_sync_q[2];
   assign sck_fall  = ~sck_sync_q[1] &  sck_sync_q[2];
   assign rx_byte   = {rx_q, mosi_sync_q[1]};
   assign byte_done = ~cs_s & sck_rise & (bit_cnt_q == 3'd7);

   assign ptr_nxt   = iocon_q[5] ? ptr_q : ((ptr_q == 8'h15) ? 8'h00 : ptr_q + 8'd1);
   assign load_vld  = byte_done & rw_q & ((state_q == ST_ADDR) | (state_q == ST_DATA));
   assign load_addr = (state_q == ST_ADDR) ? rx_byte : ptr_nxt;
   assign wr_vld    = byte_done & ~rw_q & (state_q == ST_DATA);

   assign gpio_a_val = (gpa_s_q & iodira_q) | (olata_q & ~iodira_q);
   assign gpio_b_val = (gpb_s_q & iodirb_q) | (olatb_q & ~iodirb_q);

   always_comb begin
      rd_dat = 8'h00;
      case (load_addr)
         8'h00: rd_dat = iodira_q;
         8'h01: rd_dat = iodirb_q;
         8'h04: rd_dat = gpintena_q;
         8'h05: rd_dat = gpintenb_q;
         8'h0A, 8'h0B: rd_dat = iocon_q;
         8'h0C: rd_dat = gppua_q;
         8'h0D: rd_dat = gppub_q;
         8'h0E: rd_dat = intfa_q;
         8'h0F: rd_dat = intfb_q;
         8'h10: rd_dat = intcapa_q;
         8'h11: rd_dat = intcapb_q;
         8'h12: rd_dat = gpio_a_val;
         8'h13: rd_dat = gpio_b_val;
         8'h14: rd_dat = olata_q;
         8'h15: rd_dat = olatb_q;
         default: rd_dat = 8'h00;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (cs_s) begin
         state_d = ST_OPCODE;
      end else if (byte_done) begin
         case (state_q)
            ST_OPCODE: state_d = (rx_byte[7:4] == 4'b0100 &&
                                  (!iocon_q[3] || rx_byte[3:1] == HW_ADDR)) ? ST_ADDR : ST_IGNORE;
            ST_ADDR: begin
               state_d = ST_DATA;
               ptr_d   = rx_byte;
            end
            ST_DATA: ptr_d = ptr_nxt;
            default: ;
         endcase
      end
   end

   // A simultaneous set and clear keeps the new flags and recaptures the port.
   assign clr_a   = load_vld & ((load_addr == 8'h12) | (load_addr == 8'h10));
   assign clr_b   = load_vld & ((load_addr == 8'h13) | (load_addr == 8'h11));
   assign set_a   = (gpa_s_q ^ gpa_prev_q) & gpintena_q;
   assign set_b   = (gpb_s_q ^ gpb_prev_q) & gpintenb_q;
   assign intfa_d = (clr_a ? 8'h00 : intfa_q) | set_a;
   assign intfb_d = (clr_b ? 8'h00 : intfb_q) | set_b;
   assign cap_a   = (|set_a) & (clr_a | ~(|intfa_q));
   assign cap_b   = (|set_b) & (clr_b | ~(|intfb_q));

   assign int_a  = |intfa_q;
   assign int_b  = |intfb_q;
   assign pin_a  = iocon_q[6] ? (int_a | int_b) : int_a;
   assign pin_b  = iocon_q[6] ? (int_a | int_b) : int_b;
   assign inta_o = iocon_q[1] ? pin_a : ~pin_a;
   assign intb_o = iocon_q[1] ? pin_b : ~pin_b;

   assign spi.miso    = miso_q;
   assign spi.miso_oe = miso_oe_q;
   assign gpa_out_o   = gpa_out_q;
   assign gpa_oe_o    = gpa_oe_q;
   assign gpb_out_o   = gpb_out_q;
   assign gpb_oe_o    = gpb_oe_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cs_sync_q  <= 2'b11;   sck_sync_q <= 3'b000;  mosi_sync_q <= 2'b00;
         gpa_m_q    <= 8'h00;   gpa_s_q    <= 8'h00;   gpa_prev_q  <= 8'h00;
         gpb_m_q    <= 8'h00;   gpb_s_q    <= 8'h00;   gpb_prev_q  <= 8'h00;
         state_q    <= ST_OPCODE; bit_cnt_q <= 3'd0;   rx_q        <= 7'h00;
         shreg_q    <= 8'h00;   ptr_q      <= 8'h00;   rw_q        <= 1'b0;
         miso_q     <= 1'b0;    miso_oe_q  <= 1'b0;
         iodira_q   <= 8'hFF;   iodirb_q   <= 8'hFF;   iocon_q     <= 8'h00;
         gpintena_q <= 8'h00;   gpintenb_q <= 8'h00;
         gppua_q    <= 8'h00;   gppub_q    <= 8'h00;
         intfa_q    <= 8'h00;   intfb_q    <= 8'h00;
         intcapa_q  <= 8'h00;   intcapb_q  <= 8'h00;
         olata_q    <= 8'h00;   olatb_q    <= 8'h00;
         gpa_out_q  <= 8'h00;   gpa_oe_q   <= 8'h00;
         gpb_out_q  <= 8'h00;   gpb_oe_q   <= 8'h00;
      end else begin
         cs_sync_q   <= {cs_sync_q[0], spi.cs};
         sck_sync_q  <= {sck_sync_q[1:0], spi.sck};
         mosi_sync_q <= {mosi_sync_q[0], spi.mosi};
         gpa_m_q <= gpa_in_i;  gpa_s_q <= gpa_m_q;  gpa_prev_q <= gpa_s_q;
         gpb_m_q <= gpb_in_i;  gpb_s_q <= gpb_m_q;  gpb_prev_q <= gpb_s_q;

         state_q   <= state_d;
         ptr_q     <= ptr_d;
         miso_oe_q <= ~cs_s & (state_d == ST_DATA) & rw_q;
         if (cs_s) begin
            bit_cnt_q <= 3'd0;
         end else begin
            if (sck_rise) begin
               rx_q      <= rx_byte[6:0];
               bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            // The fall right after a byte boundary keeps the freshly loaded MSB.
            if (sck_fall) begin
               if (bit_cnt_q != 3'd0) begin
                  shreg_q <= {shreg_q[6:0], 1'b0};
                  miso_q  <= shreg_q[6];
               end else begin
                  miso_q  <= shreg_q[7];
               end
            end
            if (load_vld) begin
               shreg_q <= rd_dat;
               miso_q  <= rd_dat[7];
            end
         end
         if (byte_done && state_q == ST_OPCODE) rw_q <= rx_byte[0];

         if (wr_vld) begin
            case (ptr_q)
               8'h00: iodira_q   <= rx_byte;
               8'h01: iodirb_q   <= rx_byte;
               8'h04: gpintena_q <= rx_byte;
               8'h05: gpintenb_q <= rx_byte;
               8'h0A, 8'h0B: iocon_q <= rx_byte & 8'h7E;
               8'h0C: gppua_q    <= rx_byte;
               8'h0D: gppub_q    <= rx_byte;
               8'h12, 8'h14: olata_q <= rx_byte;
               8'h13, 8'h15: olatb_q <= rx_byte;
               default: ;
            endcase
         end

         intfa_q <= intfa_d;
         intfb_q <= intfb_d;
         if (cap_a) intcapa_q <= gpa_s_q;
         if (cap_b) intcapb_q <= gpb_s_q;

         gpa_out_q <= olata_q;  gpa_oe_q <= ~iodira_q;
         gpb_out_q <= olatb_q;  gpb_oe_q <= ~iodirb_q;
      end
   end
endmodule

// File: tb/tb_mcp23s17_spi_slave.sv
// Directed bench for mcp23s17_spi_slave: acts as SPI master with hand-computed expectations.
module tb_mcp23s17_spi_slave;
   localparam int HP = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] gpa_in, gpb_in, gpa_out, gpa_oe, gpb_out, gpb_oe;
   logic       inta, intb;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   mcp23s17_spi_slave_if spi_if ();

   mcp23s17_spi_slave #(.HW_ADDR(3'b010)) dut (
      .clk       (clk),
      .rst       (rst),
      .spi       (spi_if),
      .gpa_in_i  (gpa_in),
      .gpb_in_i  (gpb_in),
      .gpa_out_o (gpa_out),
      .gpa_oe_o  (gpa_oe),
      .gpb_out_o (gpb_out),
      .gpb_oe_o  (gpb_oe),
      .inta_o    (inta),
      .intb_o    (intb)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wait_clk(4);
      rst = 1'b0;
      wait_clk(4);
   endtask

   task automatic spi_byte(input logic [7:0] tx, input int nbits,
                           output logic [7:0] rx, output logic oe);
      rx = 8'h00;
      oe = 1'b0;
      for (int i = 7; i > 7 - nbits; i--) begin
         spi_if.mosi = tx[i];
         wait_clk(HP);
         rx[i] = spi_if.miso;
         oe    = oe | spi_if.miso_oe;
         spi_if.sck = 1'b1;
         wait_clk(HP);
         spi_if.sck = 1'b0;
      end
   endtask

   task automatic cs_lo();
      spi_if.cs = 1'b0;
      wait_clk(HP);
   endtask

   task automatic cs_hi();
      wait_clk(HP);
      spi_if.cs = 1'b1;
      wait_clk(2 * HP);
   endtask

   task automatic wr(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] dat);
      logic [7:0] r;
      logic       o;
      cs_lo();
      spi_byte(op, 8, r, o);
      spi_byte(addr, 8, r, o);
      spi_byte(dat, 8, r, o);
      cs_hi();
   endtask

   task automatic rd(input logic [7:0] op, input logic [7:0] addr, input int n,
                     output logic [7:0] d0, output logic [7:0] d1, output logic oe);
      logic [7:0] r;
      logic       o, o1;
      cs_lo();
      spi_byte(op, 8, r, o);
      spi_byte(addr, 8, r, o);
      spi_byte(8'h00, 8, d0, oe);
      d1 = 8'h00;
      if (n > 1) begin
         spi_byte(8'h00, 8, d1, o1);
         oe = oe & o1;
      end
      cs_hi();
   endtask

   initial begin : stim
      logic [7:0] d0, d1, r;
      logic       oe, o;
      spi_if.cs = 1'b1;  spi_if.sck = 1'b0;  spi_if.mosi = 1'b0;
      gpa_in = 8'hFF;    gpb_in = 8'h00;
      do_reset();

      // T1 reset state
      chk("t1_gpa_oe", gpa_oe, 8'h00);
      chk("t1_gpb_oe", gpb_oe, 8'h00);
      chk("t1_gpa_out", gpa_out, 8'h00);
      chk("t1_inta", {7'b0, inta}, 8'h01);
      chk("t1_intb", {7'b0, intb}, 8'h01);
      chk("t1_miso", {7'b0, spi_if.miso}, 8'h00);
      chk("t1_miso_oe", {7'b0, spi_if.miso_oe}, 8'h00);
      rd(8'h41, 8'h00, 1, d0, d1, oe);
      chk("t1_iodira", d0, 8'hFF);
      chk("t1_rd_oe", {7'b0, oe}, 8'h01);

      // T2 writes
      wr(8'h40, 8'h0A, 8'h52);
      wr(8'h40, 8'h00, 8'h00);
      wr(8'h40, 8'h14, 8'hA5);
      chk("t2_gpa_oe", gpa_oe, 8'hFF);
      chk("t2_gpa_out", gpa_out, 8'hA5);
      chk("t2_gpb_oe", gpb_oe, 8'h00);
      chk("t2_inta_pol", {7'b0, inta}, 8'h00);
      rd(8'h41, 8'h0A, 2, d0, d1, oe);
      chk("t2_iocon", d0, 8'h52);
      chk("t2_iocon_alias", d1, 8'h52);
      rd(8'h41, 8'h12, 1, d0, d1, oe);
      chk("t2_gpio_from_olat", d0, 8'hA5);

      // T3 interrupt on change
      do_reset();
      wr(8'h40, 8'h0A, 8'h52);
      wr(8'h40, 8'h04, 8'hFF);
      chk("t3_inta_idle", {7'b0, inta}, 8'h00);
      gpa_in = 8'hFE;
      for (int k = 0; k < 4; k++) begin
         wait_clk(1);
         if (inta === 1'b1) break;
      end
      chk("t3_inta_set", {7'b0, inta}, 8'h01);
      chk("t3_intb_mirror", {7'b0, intb}, 8'h01);
      rd(8'h41, 8'h0E, 1, d0, d1, oe);
      chk("t3_intfa", d0, 8'h01);
      chk("t3_inta_held", {7'b0, inta}, 8'h01);
      rd(8'h41, 8'h12, 1, d0, d1, oe);
      chk("t3_gpioa", d0, 8'hFE);
      chk("t3_inta_clr", {7'b0, inta}, 8'h00);
      rd(8'h41, 8'h10, 1, d0, d1, oe);
      chk("t3_intcapa", d0, 8'hFE);

      // T4 sequential read
      do_reset();
      gpa_in = 8'h3C;  gpb_in = 8'hC3;
      wait_clk(4);
      rd(8'h41, 8'h12, 2, d0, d1, oe);
      chk("t4_seq_b0", d0, 8'h3C);
      chk("t4_seq_b1", d1, 8'hC3);
      chk("t4_seq_oe", {7'b0, oe}, 8'h01);
      wr(8'h40, 8'h0A, 8'h20);
      rd(8'h41, 8'h12, 2, d0, d1, oe);
      chk("t4_seqop_b0", d0, 8'h3C);
      chk("t4_seqop_b1", d1, 8'h3C);

      // T5 hardware address match
      do_reset();
      wr(8'h40, 8'h0A, 8'h08);
      wr(8'h40, 8'h14, 8'h77);
      rd(8'h41, 8'h14, 1, d0, d1, oe);
      chk("t5_mismatch_oe", {7'b0, oe}, 8'h00);
      chk("t5_mismatch_olat", gpa_out, 8'h00);
      rd(8'h45, 8'h14, 1, d0, d1, oe);
      chk("t5_match_olat", d0, 8'h00);
      chk("t5_match_oe", {7'b0, oe}, 8'h01);
      rd(8'h45, 8'h0A, 1, d0, d1, oe);
      chk("t5_iocon", d0, 8'h08);
      wr(8'h44, 8'h14, 8'h5A);
      chk("t5_match_wr", gpa_out, 8'h5A);

      // T6 aborted data byte
      cs_lo();
      spi_byte(8'h44, 8, r, o);
      spi_byte(8'h14, 8, r, o);
      spi_byte(8'hAB, 4, r, o);
      cs_hi();
      chk("t6_abort_out", gpa_out, 8'h5A);
      rd(8'h45, 8'h14, 1, d0, d1, oe);
      chk("t6_abort_olat", d0, 8'h5A);
      wr(8'h44, 8'h15, 8'hC3);
      chk("t6_next_frame", gpb_out, 8'hC3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
